array_alloc_ctrl: RTL
=====================

ARRAY_ALLOC_CTRL -- requirements
Module: array_alloc_ctrl

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, meaning data/index width W.
REQ-002 SHALL have parameter NArrays, default 64, meaning maximum number of arrays.
REQ-003 SHALL have parameter NArea, default 10, meaning heap words per array; NArrays*NArea SHALL be <= 2**W.
REQ-004 SHALL have ports: clock  in  1  single clock, all state on posedge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low.
REQ-006 SHALL have ports: allocReq  in  1  level request for a new array, held until allocAck.
REQ-007 SHALL have ports: allocAck  out  1  one-cycle pulse; allocArray valid.
REQ-008 SHALL have ports: allocArray  out  W  allocated array number.
REQ-009 SHALL have ports: freeReq  in  1  level request to release freeArray, held until freeAck.
REQ-010 SHALL have ports: freeArray  in  W  array number being released.
REQ-011 SHALL have ports: freeAck  out  1  one-cycle pulse.
REQ-012 SHALL have ports: heapWe / heapAddr / heapData  out  1 / W / W  heap clear write port.
REQ-013 SHALL have ports: sizeWe / sizeIndex  out  1 / W  write arraySizes[sizeIndex] = 0.
REQ-014 SHALL have ports: busy  out  1; exhausted  out  1; inUse  out  W; allocs  out  W (high-water mark); error  out  1 (sticky).

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, ACK; one request accepted per IDLE cycle.
REQ-016 In IDLE with freeReq high, free SHALL take priority over allocReq (simultaneous requests: free first, alloc next IDLE cycle).
REQ-017 Free: push freeArray onto free stack, inUse-1, freeAck pulses the following cycle, state stays IDLE; freeReq SHALL be ignored for the cycle freeAck is high.
REQ-018 Alloc source: pop free stack (LIFO) if non-empty, else next fresh index (counter 0..NArrays-1).
REQ-019 Alloc accepted: sizeWe=1, sizeIndex=array for exactly one cycle (the IDLE->CLEAR cycle); state -> CLEAR.
REQ-020 CLEAR: NArea cycles, heapWe=1, heapData=0, heapAddr=array*NArea+k, k=0..NArea-1 ascending; then ACK.
REQ-021 ACK: allocAck=1, allocArray=array for one cycle, inUse+1, allocs=max(allocs,inUse+1); then IDLE.
REQ-022 Alloc latency SHALL be NArea+2 cycles from sampled allocReq to allocAck.
REQ-023 exhausted SHALL be high when free stack empty and fresh counter == NArrays; alloc request while exhausted SHALL set error, not ack, not change state.
REQ-024 Free when inUse==0 or freeArray >= NArrays SHALL set error and not push; freeAck still pulses.
REQ-025 busy SHALL be high in CLEAR and ACK.
REQ-026 heapWe, sizeWe, allocAck, freeAck SHALL be 0 whenever not specified above.

Reset
REQ-027 Reset low SHALL immediately force: state IDLE, free stack empty, fresh counter 0, inUse 0, allocs 0, error 0, all outputs 0.
REQ-028 Reset mid-CLEAR SHALL abandon the allocation; no allocAck after release.

Configuration
REQ-029 With ARRAY_ALLOC_CLEAR_EN defined: CLEAR state as REQ-020, latency NArea+2.
REQ-030 Without ARRAY_ALLOC_CLEAR_EN: CLEAR omitted (IDLE->ACK), heapWe tied 0, latency 2; size clear unchanged.

Structure
REQ-031 Package fpga_pkg SHALL hold the FSM state enum and default MemoryElementWidth/NArea constants.
REQ-032 Free stack SHALL be sub-module array_free_stack (depth NArrays, push/pop/empty/full, synchronous).

Verification
REQ-033 Reset, allocReq held -> sizeWe idx 0, heapWe addr 0..9 data 0, allocAck array 0 at cycle 12; inUse=1, allocs=1.
REQ-034 Alloc 0,1,2; free 1; alloc -> allocArray 1 (LIFO reuse); allocs=3, inUse=3.
REQ-035 allocReq and freeReq(0) same cycle after alloc 0 -> freeAck first, then alloc returns 0.
REQ-036 NArrays=4: alloc 4 times, 5th request -> exhausted=1, error=1, no allocAck.
REQ-037 Free with inUse=0 -> error=1, freeAck pulses, inUse stays 0.
REQ-038 Reset asserted at CLEAR k=5 -> outputs 0 at once, no allocAck, next alloc returns array 0.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared FSM state type and default sizing for the array allocator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpga_pkg;

    localparam int DefMemoryElementWidth = 12;
    localparam int DefNArea              = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACK   = 2'd2
    } alloc_state_e;

endpackage

// File: rtl/array_free_stack.sv
// LIFO of released array numbers; push/pop take effect on the clock edge, top_dat is combinational.
// Latency: a pushed entry is visible on top_dat the cycle after the push.
// Backpressure: push while full and pop while empty are dropped; caller watches full/empty.
module array_free_stack
    import fpga_pkg::*;
#(
    parameter int Width = DefMemoryElementWidth,
    parameter int Depth = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] push_dat,
    output logic [Width-1:0] top_dat,
    output logic             empty,
    output logic             full
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PW:0]   DepthC = (PW + 1)'(Depth);
    localparam logic [PW:0]   CntOne = (PW + 1)'(1);
    localparam logic [PW-1:0] IdxOne = PW'(1);

    logic [Width-1:0] mem [Depth];
    logic [PW:0]      count_q;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    top_idx;

    assign wr_idx  = count_q[PW-1:0];
    assign top_idx = count_q[PW-1:0] - IdxOne;
    assign empty   = (count_q == '0);
    assign full    = (count_q == DepthC);
    assign top_dat = mem[top_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (push && !pop && !full) begin
            count_q <= count_q + CntOne;
        end else if (pop && !push && !empty) begin
            count_q <= count_q - CntOne;
        end
    end

    // Simultaneous push+pop replaces the top entry in place.
    always_ff @(posedge clock) begin
        if (push && pop && !empty) begin
            mem[top_idx] <= push_dat;
        end else if (push && !pop && !full) begin
            mem[wr_idx] <= push_dat;
        end
    end

endmodule

// File: rtl/array_alloc_ctrl.sv
// Array allocator: LIFO reuse of freed arrays, fresh indices otherwise; optional heap clear (ARRAY_ALLOC_CLEAR_EN).
// Latency: alloc NArea+2 cycles with clear, 2 without; free acks the cycle after acceptance.
// Backpressure: level requests held until their ack; one request accepted per IDLE cycle, free first.
module array_alloc_ctrl
    import fpga_pkg::*;
#(
    parameter int MemoryElementWidth = DefMemoryElementWidth,
    parameter int NArrays            = 64,
    parameter int NArea              = DefNArea
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          allocReq,
    output logic                          allocAck,
    output logic [MemoryElementWidth-1:0] allocArray,
    input  logic                          freeReq,
    input  logic [MemoryElementWidth-1:0] freeArray,
    output logic                          freeAck,
    output logic                          heapWe,
    output logic [MemoryElementWidth-1:0] heapAddr,
    output logic [MemoryElementWidth-1:0] heapData,
    output logic                          sizeWe,
    output logic [MemoryElementWidth-1:0] sizeIndex,
    output logic                          busy,
    output logic                          exhausted,
    output logic [MemoryElementWidth-1:0] inUse,
    output logic [MemoryElementWidth-1:0] allocs,
    output logic                          error
);

    localparam int W = MemoryElementWidth;
    localparam logic [W:0]   NArraysC = (W + 1)'(NArrays);
    localparam logic [W:0]   FreshOne = (W + 1)'(1);
    localparam logic [W-1:0] OneW     = W'(1);

    alloc_state_e   state_q, state_d;
    logic [W-1:0]   arr_q, inuse_q, allocs_q, inuse_inc, stk_top, new_arr;
    logic [W:0]     fresh_q;
    logic           error_q, alloc_ack_q, free_ack_q, size_we_q;
    logic           stk_empty, stk_full, exhausted_c, idle;
    logic           take_free, free_ok, alloc_sel, take_alloc, alloc_denied;

    assign exhausted_c  = stk_empty && (fresh_q == NArraysC);
    assign idle         = (state_q == ST_IDLE);
    // A request is ignored in the cycle its own ack is showing, so a held level is not taken twice.
    assign take_free    = idle && freeReq && !free_ack_q;
    assign alloc_sel    = idle && !take_free && allocReq && !alloc_ack_q;
    assign take_alloc   = alloc_sel && !exhausted_c;
    assign alloc_denied = alloc_sel && exhausted_c;
    assign free_ok      = take_free && (inuse_q != '0) && ({1'b0, freeArray} < NArraysC) && !stk_full;
    assign new_arr      = stk_empty ? fresh_q[W-1:0] : stk_top;
    assign inuse_inc    = inuse_q + OneW;

    array_free_stack #(
        .Width (W),
        .Depth (NArrays)
    ) u_free_stack (
        .clock    (clock),
        .reset    (reset),
        .push     (free_ok),
        .pop      (take_alloc && !stk_empty),
        .push_dat (freeArray),
        .top_dat  (stk_top),
        .empty    (stk_empty),
        .full     (stk_full)
    );

`ifdef ARRAY_ALLOC_CLEAR_EN
    localparam int KW = (NArea > 1) ? $clog2(NArea) : 1;
    localparam logic [KW-1:0] KLast  = KW'(NArea - 1);
    localparam logic [W-1:0]  NAreaC = W'(NArea);
    localparam alloc_state_e  AfterIdle = ST_CLEAR;

    logic [KW-1:0] clr_k_q;
    logic [W-1:0]  heap_ptr_q, heap_addr_q;
    logic          heap_we_q;

    // Heap writes trail the CLEAR state by one cycle, like every other registered strobe here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_k_q     <= '0;
            heap_ptr_q  <= '0;
            heap_addr_q <= '0;
            heap_we_q   <= 1'b0;
        end else begin
            heap_we_q   <= (state_q == ST_CLEAR);
            heap_addr_q <= heap_ptr_q;
            if (take_alloc) begin
                heap_ptr_q <= new_arr * NAreaC;
                clr_k_q    <= '0;
            end else if (state_q == ST_CLEAR) begin
                heap_ptr_q <= heap_ptr_q + OneW;
                clr_k_q    <= clr_k_q + KW'(1);
            end
        end
    end

    assign heapWe   = heap_we_q;
    assign heapAddr = heap_addr_q;
`else
    localparam alloc_state_e AfterIdle = ST_ACK;

    assign heapWe   = 1'b0;
    assign heapAddr = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (take_alloc) state_d = AfterIdle;
`ifdef ARRAY_ALLOC_CLEAR_EN
            ST_CLEAR: if (clr_k_q == KLast) state_d = ST_ACK;
`endif
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            arr_q       <= '0;
            fresh_q     <= '0;
            inuse_q     <= '0;
            allocs_q    <= '0;
            error_q     <= 1'b0;
            alloc_ack_q <= 1'b0;
            free_ack_q  <= 1'b0;
            size_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alloc_ack_q <= (state_q == ST_ACK);
            free_ack_q  <= take_free;
            size_we_q   <= take_alloc;
            if (take_alloc) begin
                arr_q <= new_arr;
                if (stk_empty) fresh_q <= fresh_q + FreshOne;
            end
            if (state_q == ST_ACK) begin
                inuse_q <= inuse_inc;
                if (inuse_inc > allocs_q) allocs_q <= inuse_inc;
            end else if (free_ok) begin
                inuse_q <= inuse_q - OneW;
            end
            if (alloc_denied || (take_free && !free_ok)) error_q <= 1'b1;
        end
    end

    assign allocAck   = alloc_ack_q;
    assign allocArray = arr_q;
    assign freeAck    = free_ack_q;
    assign heapData   = '0;
    assign sizeWe     = size_we_q;
    assign sizeIndex  = arr_q;
    assign busy       = !idle;
    assign exhausted  = exhausted_c;
    assign inUse      = inuse_q;
    assign allocs     = allocs_q;
    assign error      = error_q;

endmodule
